// File: rtl/traffic_control_pkg.sv
// Shared types and default timing for the traffic_control intersection controller:
// state encoding, lamp bundle and the per-state lamp decode.
package traffic_control_pkg;

    typedef enum logic [2:0] {
        A_GREEN,
        A_YELLOW,
        B_GREEN,
        B_YELLOW,
        PED_GREEN,
        PED_FLASH,
        FAILURE,
        RECOVER
    } state_t;

    localparam int DEF_T_GREEN_A_MIN = 8;
    localparam int DEF_T_YELLOW      = 2;
    localparam int DEF_T_GREEN_B_MIN = 3;
    localparam int DEF_T_GREEN_B_MAX = 10;
    localparam int DEF_T_PED_GREEN   = 6;
    localparam int DEF_T_PED_FLASH   = 3;
    localparam int DEF_T_RECOVER     = 2;

    typedef struct packed {
        logic green_a;
        logic yellow_a;
        logic red_a;
        logic fy_a;
        logic green_b;
        logic yellow_b;
        logic red_b;
        logic fy_b;
        logic red_x;
        logic green_x;
        logic flash_x;
    } lamps_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One lamp per road head; the crossing head goes fully dark only in FAILURE.
    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l = '0;
        case (s)
            A_GREEN: begin
                l.green_a = 1'b1;
                l.red_b   = 1'b1;
                l.red_x   = 1'b1;
            end
            A_YELLOW: begin
                l.yellow_a = 1'b1;
                l.red_b    = 1'b1;
                l.red_x    = 1'b1;
            end
            B_GREEN: begin
                l.red_a   = 1'b1;
                l.green_b = 1'b1;
                l.red_x   = 1'b1;
            end
            B_YELLOW: begin
                l.red_a    = 1'b1;
                l.yellow_b = 1'b1;
                l.red_x    = 1'b1;
            end
            PED_GREEN: begin
                l.red_a   = 1'b1;
                l.red_b   = 1'b1;
                l.green_x = 1'b1;
            end
            PED_FLASH: begin
                l.red_a   = 1'b1;
                l.red_b   = 1'b1;
                l.flash_x = 1'b1;
            end
            FAILURE: begin
                l.fy_a = 1'b1;
                l.fy_b = 1'b1;
            end
            RECOVER: begin
                l.red_a = 1'b1;
                l.red_b = 1'b1;
                l.red_x = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_control_timer.sv
// Saturating cycle counter for traffic_control: cleared on state entry,
// flags when the current state has lasted tc_i cycles.
module traffic_control_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic [W-1:0] tc_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W:0]   ONE_X = (W + 1)'(1);

    logic [W-1:0] count_q, count_d;

    // Saturate so a long wait (e.g. A_GREEN with no demand) never wraps.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (count_q != {W{1'b1}}) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = ({1'b0, count_q} + ONE_X) >= {1'b0, tc_i};

endmodule

// File: rtl/traffic_control.sv
// Two-road intersection controller with pedestrian crossing over road A.
// Optional emergency preemption via RadioSensor is enabled by EMERGENCY_PREEMPT_EN.
module traffic_control
    import traffic_control_pkg::*;
#(
    parameter int T_GREEN_A_MIN = DEF_T_GREEN_A_MIN,
    parameter int T_YELLOW      = DEF_T_YELLOW,
    parameter int T_GREEN_B_MIN = DEF_T_GREEN_B_MIN,
    parameter int T_GREEN_B_MAX = DEF_T_GREEN_B_MAX,
    parameter int T_PED_GREEN   = DEF_T_PED_GREEN,
    parameter int T_PED_FLASH   = DEF_T_PED_FLASH,
    parameter int T_RECOVER     = DEF_T_RECOVER
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Key,
    input  logic Car,
    input  logic RadioSensor,
    input  logic FailureDetect,
    output logic GreenA,
    output logic YellowA,
    output logic RedA,
    output logic FlashingYellowA,
    output logic GreenB,
    output logic YellowB,
    output logic RedB,
    output logic FlashingYellowB,
    output logic RedCrossing,
    output logic GreenCrossing,
    output logic FlashingGreenCrossing
);

    localparam int T_MAX = max_int(max_int(max_int(T_GREEN_A_MIN, T_YELLOW),
                                           max_int(T_GREEN_B_MIN, T_GREEN_B_MAX)),
                                   max_int(max_int(T_PED_GREEN, T_PED_FLASH), T_RECOVER));
    localparam int TW = ($clog2(T_MAX + 1) > 8) ? $clog2(T_MAX + 1) : 8;

    state_t        state_q, state_d;
    logic          keyreq_q, keyreq_d;
    lamps_t        lamps_q, lamps_d;
    logic          radio;
    logic [TW-1:0] tc_sel;
    logic [TW-1:0] tmr_count;
    logic          tmr_done;
    logic          tmr_clr;
    logic          b_max_hit;

`ifdef EMERGENCY_PREEMPT_EN
    assign radio = RadioSensor;
`else
    // Preemption disabled: the input is masked to a constant 0.
    assign radio = RadioSensor & 1'b0;
`endif

    always_comb begin
        tc_sel = TW'(1);
        case (state_q)
            A_GREEN:   tc_sel = TW'(T_GREEN_A_MIN);
            A_YELLOW:  tc_sel = TW'(T_YELLOW);
            B_GREEN:   tc_sel = TW'(T_GREEN_B_MIN);
            B_YELLOW:  tc_sel = TW'(T_YELLOW);
            PED_GREEN: tc_sel = TW'(T_PED_GREEN);
            PED_FLASH: tc_sel = TW'(T_PED_FLASH);
            RECOVER:   tc_sel = TW'(T_RECOVER);
            FAILURE:   tc_sel = TW'(1);
        endcase
    end

    assign b_max_hit = tmr_count >= TW'(T_GREEN_B_MAX - 1);

    always_comb begin
        state_d = state_q;
        if (FailureDetect) begin
            state_d = FAILURE;
        end else begin
            case (state_q)
                A_GREEN: begin
                    if (radio || (tmr_done && (keyreq_q || Car))) begin
                        state_d = A_YELLOW;
                    end
                end
                A_YELLOW: begin
                    if (tmr_done) begin
                        if (radio)         state_d = B_GREEN;
                        else if (keyreq_q) state_d = PED_GREEN;
                        else               state_d = B_GREEN;
                    end
                end
                B_GREEN: begin
                    // An emergency vehicle holds road B with no upper bound.
                    if (!radio && ((tmr_done && (!Car || keyreq_q)) || b_max_hit)) begin
                        state_d = B_YELLOW;
                    end
                end
                B_YELLOW: begin
                    if (tmr_done) begin
                        if (radio)         state_d = B_GREEN;
                        else if (keyreq_q) state_d = PED_GREEN;
                        else               state_d = A_GREEN;
                    end
                end
                PED_GREEN: begin
                    if (radio || tmr_done) begin
                        state_d = PED_FLASH;
                    end
                end
                PED_FLASH: begin
                    if (tmr_done) begin
                        state_d = radio ? B_GREEN : A_GREEN;
                    end
                end
                FAILURE: begin
                    state_d = RECOVER;
                end
                RECOVER: begin
                    if (tmr_done) begin
                        state_d = A_GREEN;
                    end
                end
            endcase
        end
    end

    assign tmr_clr = (state_d != state_q);

    // A press on the very edge that enters PED_GREEN is kept for the next cycle.
    assign keyreq_d = (keyreq_q && !((state_d == PED_GREEN) && (state_q != PED_GREEN))) || Key;

    assign lamps_d = decode_lamps(state_d);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= A_GREEN;
            keyreq_q <= 1'b0;
            lamps_q  <= decode_lamps(A_GREEN);
        end else begin
            state_q  <= state_d;
            keyreq_q <= keyreq_d;
            lamps_q  <= lamps_d;
        end
    end

    traffic_control_timer #(
        .W (TW)
    ) u_timer (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .clr_i   (tmr_clr),
        .tc_i    (tc_sel),
        .count_o (tmr_count),
        .done_o  (tmr_done)
    );

    assign GreenA                = lamps_q.green_a;
    assign YellowA               = lamps_q.yellow_a;
    assign RedA                  = lamps_q.red_a;
    assign FlashingYellowA       = lamps_q.fy_a;
    assign GreenB                = lamps_q.green_b;
    assign YellowB               = lamps_q.yellow_b;
    assign RedB                  = lamps_q.red_b;
    assign FlashingYellowB       = lamps_q.fy_b;
    assign RedCrossing           = lamps_q.red_x;
    assign GreenCrossing         = lamps_q.green_x;
    assign FlashingGreenCrossing = lamps_q.flash_x;

endmodule

// File: tb/tb_traffic_control.sv
// Table-driven bench for traffic_control: per-cycle lamp checks against
// hand-computed phase sequences, plus a mid-phase asynchronous reset sequence.
module tb_traffic_control;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic Key = 1'b0;
    logic Car = 1'b0;
    logic RadioSensor = 1'b0;
    logic FailureDetect = 1'b0;
    logic GreenA, YellowA, RedA, FlashingYellowA;
    logic GreenB, YellowB, RedB, FlashingYellowB;
    logic RedCrossing, GreenCrossing, FlashingGreenCrossing;

    // {GA,YA,RA,FYA, GB,YB,RB,FYB, RX,GX,FX}
    localparam logic [10:0] AG = 11'b1000_0010_100;
    localparam logic [10:0] AY = 11'b0100_0010_100;
    localparam logic [10:0] BG = 11'b0010_1000_100;
    localparam logic [10:0] BY = 11'b0010_0100_100;
    localparam logic [10:0] PG = 11'b0010_0010_010;
    localparam logic [10:0] PF = 11'b0010_0010_001;
    localparam logic [10:0] FL = 11'b0001_0001_000;
    localparam logic [10:0] RC = 11'b0010_0010_100;

    typedef struct {
        logic        rst_first;
        logic        key;
        logic        car;
        logic        radio;
        logic        fail;
        int          reps;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[64];
    int   nvec   = 0;
    int   checks = 0;
    int   errors = 0;

    wire [10:0] lamps = {GreenA, YellowA, RedA, FlashingYellowA,
                         GreenB, YellowB, RedB, FlashingYellowB,
                         RedCrossing, GreenCrossing, FlashingGreenCrossing};

    traffic_control dut (
        .Clk                   (Clk),
        .Rst                   (Rst),
        .Key                   (Key),
        .Car                   (Car),
        .RadioSensor           (RadioSensor),
        .FailureDetect         (FailureDetect),
        .GreenA                (GreenA),
        .YellowA               (YellowA),
        .RedA                  (RedA),
        .FlashingYellowA       (FlashingYellowA),
        .GreenB                (GreenB),
        .YellowB               (YellowB),
        .RedB                  (RedB),
        .FlashingYellowB       (FlashingYellowB),
        .RedCrossing           (RedCrossing),
        .GreenCrossing         (GreenCrossing),
        .FlashingGreenCrossing (FlashingGreenCrossing)
    );

    always #5 Clk = ~Clk;

    task automatic add(input logic rf, input logic k, input logic c, input logic r,
                       input logic f, input int n, input logic [10:0] e);
        vecs[nvec] = '{rf, k, c, r, f, n, e};
        nvec++;
    endtask

    task automatic check(input string name, input logic [10:0] want);
        checks++;
        if (lamps !== want) begin
            errors++;
            $display("FAIL %s lamps got %b want %b", name, lamps, want);
        end else begin
            $display("ok   %s lamps %b", name, lamps);
        end
    endtask

    // Called #1 after a rising edge; leaves the next rising edge as cycle 1.
    task automatic do_reset(input string tag);
        Key = 1'b0; Car = 1'b0; RadioSensor = 1'b0; FailureDetect = 1'b0;
        Rst = 1'b1;
        #2;
        check({tag, "_rst_async"}, AG);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check({tag, "_rst_release"}, AG);
    endtask

    task automatic steps(input string tag, input int n, input logic [10:0] want);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            check($sformatf("%s.%0d", tag, i), want);
        end
    endtask

    initial begin
        // Car on road B: A green 8, A yellow 2, B green until Car drops after 5, B yellow 2.
        add(1, 0, 0, 0, 0, 2, AG);
        add(0, 0, 1, 0, 0, 5, AG);
        add(0, 0, 1, 0, 0, 2, AY);
        add(0, 0, 1, 0, 0, 5, BG);
        add(0, 0, 0, 0, 0, 2, BY);
        add(0, 0, 0, 0, 0, 3, AG);
        // Single-cycle key pulse: full pedestrian phase, then request is gone.
        add(1, 1, 0, 0, 0, 1, AG);
        add(0, 0, 0, 0, 0, 6, AG);
        add(0, 0, 0, 0, 0, 2, AY);
        add(0, 0, 0, 0, 0, 6, PG);
        add(0, 0, 0, 0, 0, 3, PF);
        add(0, 0, 0, 0, 0, 12, AG);
`ifdef EMERGENCY_PREEMPT_EN
        // Radio at cycle 2 preempts A with no minimum; B held while radio stays high.
        add(1, 0, 0, 0, 0, 1, AG);
        add(0, 0, 0, 1, 0, 2, AY);
        add(0, 0, 0, 1, 0, 20, BG);
        add(0, 0, 0, 0, 0, 2, BY);
        add(0, 0, 0, 0, 0, 2, AG);
`else
        // Radio ignored entirely.
        add(1, 0, 0, 1, 0, 12, AG);
`endif
        // Failure for 6 cycles from B green, then recover, then single-cycle pulses.
        add(1, 0, 1, 0, 0, 7, AG);
        add(0, 0, 1, 0, 0, 2, AY);
        add(0, 0, 1, 0, 0, 3, BG);
        add(0, 0, 0, 0, 1, 6, FL);
        add(0, 0, 0, 0, 0, 2, RC);
        add(0, 0, 0, 0, 0, 3, AG);
        add(0, 0, 0, 0, 1, 1, FL);
        add(0, 0, 0, 0, 0, 2, RC);
        add(0, 0, 0, 0, 0, 1, AG);
`ifdef EMERGENCY_PREEMPT_EN
        // Failure beats radio; radio still held after recovery preempts A at once.
        add(0, 0, 0, 1, 1, 1, FL);
        add(0, 0, 0, 1, 0, 2, RC);
        add(0, 0, 0, 1, 0, 1, AG);
        add(0, 0, 0, 1, 0, 2, AY);
        add(0, 0, 0, 1, 0, 1, BG);
`else
        add(0, 0, 0, 1, 1, 1, FL);
        add(0, 0, 0, 1, 0, 2, RC);
        add(0, 0, 0, 1, 0, 4, AG);
`endif
        // Car held: B green capped at exactly 10 cycles.
        add(1, 0, 1, 0, 0, 7, AG);
        add(0, 0, 1, 0, 0, 2, AY);
        add(0, 0, 1, 0, 0, 10, BG);
        add(0, 0, 1, 0, 0, 2, BY);
        add(0, 0, 1, 0, 0, 8, AG);
        add(0, 0, 1, 0, 0, 1, AY);

        @(posedge Clk);
        #1;
        for (int v = 0; v < nvec; v++) begin
            if (vecs[v].rst_first) do_reset($sformatf("v%0d", v));
            Key           = vecs[v].key;
            Car           = vecs[v].car;
            RadioSensor   = vecs[v].radio;
            FailureDetect = vecs[v].fail;
            steps($sformatf("v%0d", v), vecs[v].reps, vecs[v].exp);
        end

        // Reset during PED_GREEN aborts the phase and drops the pending request.
        do_reset("ped");
        Key = 1'b1;
        steps("ped_key", 1, AG);
        Key = 1'b0;
        steps("ped_ag", 6, AG);
        steps("ped_ay", 2, AY);
        steps("ped_pg", 3, PG);
        Rst = 1'b1;
        #2;
        check("ped_mid_rst_async", AG);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("ped_rst_release", AG);
        steps("ped_no_repeat", 15, AG);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_control.md
# traffic_control

Two-road intersection controller with a pedestrian crossing over road A. Road A, the main road, rests on green. Road B is served when any of these occur:
- a car is detected on road B;
- an emergency vehicle is reported by radio;
- a pedestrian presses the request key.

A lamp-failure input forces both roads into flashing-yellow mode. The block is a Moore FSM with cycle timers and sits between the sensor front-end and the lamp drivers.

## Interface
Parameters (cycle counts):
- T_GREEN_A_MIN, 8, minimum road-A green before it can be preempted by Car or Key.
- T_YELLOW, 2, yellow duration for either road.
- T_GREEN_B_MIN, 3, minimum road-B green.
- T_GREEN_B_MAX, 10, maximum road-B green when served for Car.
- T_PED_GREEN, 6, steady crossing green.
- T_PED_FLASH, 3, flashing crossing green.
- T_RECOVER, 2, all-red time after a failure clears.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset, asynchronous and active-high.
- Key  in  1  pedestrian request.
- Car  in  1  car present on road B (level).
- RadioSensor  in  1  emergency vehicle on road B (level).
- FailureDetect  in  1  lamp failure (level).
- GreenA, YellowA, RedA, FlashingYellowA  out  1 each  road-A head.
- GreenB, YellowB, RedB, FlashingYellowB  out  1 each  road-B head.
- RedCrossing, GreenCrossing, FlashingGreenCrossing  out  1 each  crossing head.

All inputs are synchronous to Clk; any synchronisation is done upstream.

## Operation
- **States:** A_GREEN, A_YELLOW, B_GREEN, B_YELLOW, PED_GREEN, PED_FLASH, FAILURE, RECOVER.
- **Lamp discipline:**
  - Each road head has exactly one lamp active.
  - The crossing head has exactly one lamp active, except in FAILURE, where all crossing lamps are 0.
  - Flashing* outputs are mode flags held at steady 1; the lamp driver generates the blink.
- **Outputs per state:**
  - A_GREEN: GreenA, RedB, RedCrossing.
  - A_YELLOW: YellowA, RedB, RedCrossing.
  - B_GREEN: RedA, GreenB, RedCrossing.
  - B_YELLOW: RedA, YellowB, RedCrossing.
  - PED_GREEN: RedA, RedB, GreenCrossing.
  - PED_FLASH: RedA, RedB, FlashingGreenCrossing.
  - FAILURE: FlashingYellowA, FlashingYellowB; all crossing lamps 0.
  - RECOVER: RedA, RedB, RedCrossing.
- **Key request latch (KeyReq):**
  - Set on any cycle with Key=1.
  - Cleared on entry to PED_GREEN and on reset.
- **Priority:** FailureDetect > RadioSensor > KeyReq > Car.
- **Transitions:**
  - Any state, FailureDetect=1: go to FAILURE on the next edge.
  - FAILURE, FailureDetect=0: go to RECOVER, stay T_RECOVER cycles, then go to A_GREEN.
  - A_GREEN:
    - RadioSensor=1: go to A_YELLOW immediately, with no minimum time.
    - Otherwise, after T_GREEN_A_MIN cycles, go to A_YELLOW if KeyReq or Car.
  - A_YELLOW, after T_YELLOW cycles:
    - RadioSensor=1: go to B_GREEN.
    - Else if KeyReq: go to PED_GREEN.
    - Else: go to B_GREEN.
  - B_GREEN:
    - Stays while RadioSensor=1, with no maximum.
    - Otherwise leaves for B_YELLOW after T_GREEN_B_MIN cycles if Car=0 or KeyReq, or at T_GREEN_B_MAX cycles.
  - B_YELLOW, after T_YELLOW cycles:
    - RadioSensor=1: go to B_GREEN.
    - Else if KeyReq: go to PED_GREEN.
    - Else: go to A_GREEN.
  - PED_GREEN:
    - After T_PED_GREEN cycles: go to PED_FLASH.
    - RadioSensor=1: go to PED_FLASH immediately.
  - PED_FLASH:
    - After T_PED_FLASH cycles: go to B_GREEN if RadioSensor=1, else A_GREEN.
- **Timer:**
  - Cleared on every state entry.
  - A state of duration T occupies exactly T cycles.
  - Timer width is wide enough for the largest parameter; minimum 8 bits.
- **Reset:**
  - State goes to A_GREEN, timer to 0, KeyReq to 0.
  - Outputs are GreenA=1, RedB=1, RedCrossing=1; all other outputs 0.
  - Reset asserted mid-phase aborts the phase immediately.

## Timing
- Outputs are registered and decoded from the state register.
- An input condition sampled at edge n is reflected on the outputs after edge n; latency is 1 cycle.
- FailureDetect pulses of a single cycle are honoured.
- Key pulses of a single cycle are latched.
- Car is level-sensitive only; a Car pulse that ends before A_GREEN's minimum time expires is not remembered.
- Simultaneous FailureDetect and RadioSensor: FAILURE wins.
- RadioSensor held through FAILURE: after RECOVER, the normal A_GREEN preemption applies.

## Configuration
- EMERGENCY_PREEMPT_EN
  - Defined: RadioSensor behaves as specified above.
  - Undefined: RadioSensor is ignored and treated as 0 everywhere.

## Structure
- Package traffic_control_pkg holds the state enum and the default timing constants.
- Sub-module traffic_control_timer: a cycle counter with clear and terminal-count compare, instantiated once.

## Test plan
- Reset, Car=1 from cycle 3: GreenA held 8 cycles, YellowA 2, then GreenB; Car=0 after GreenB's 5th cycle gives YellowB for 2 cycles, then GreenA.
- Key pulse for 1 cycle during A_GREEN: after A_GREEN's minimum time, YellowA 2, GreenCrossing 6, FlashingGreenCrossing 3, then GreenA; KeyReq cleared.
- RadioSensor=1 during A_GREEN at cycle 2: YellowA next cycle for 2 cycles, then GreenB held for 20 cycles while RadioSensor=1; YellowB after it drops.
- FailureDetect=1 for 6 cycles from B_GREEN: FlashingYellowA=FlashingYellowB=1 and crossing lamps 0 from the next cycle; then all-red 2 cycles, then GreenA.
- Rst asserted mid-PED_GREEN for 1 cycle: outputs go immediately (asynchronously) to GreenA/RedB/RedCrossing, and no pedestrian phase repeats.
- Car=1 held continuously: GreenB ends at exactly 10 cycles.
